// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, dump-FSM state encoding and the
// branch-resolution helper used by the memory stage.
package cpu_pkg;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_JAL = 6'b000011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DUMP = 2'd1,
    ST_DONE = 2'd2
  } dumpState_t;

  // beq is taken on a zero ALU result (equal operands), bne on non-zero.
  function automatic logic branchTaken(input logic        branch,
                                       input logic [5:0]  aluOp,
                                       input logic [31:0] aluOut);
    logic isZero;
    isZero = (aluOut == 32'd0);
    return branch && (((aluOp == OP_BEQ) && isZero) ||
                      ((aluOp == OP_BNE) && !isZero));
  endfunction

endpackage

// File: rtl/main_ram.sv
// Word-addressed data RAM: one synchronous write port, one asynchronous read
// port for loads and a second asynchronous read port for the dump stream.
module main_ram #(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic          CLK,
  input  logic          writeEn,
  input  logic [AW-1:0] writeAddr,
  input  logic [31:0]   writeData,
  input  logic [AW-1:0] readAddr,
  output logic [31:0]   readData,
  input  logic [AW-1:0] dumpAddr,
  output logic [31:0]   dumpData
);

  logic [31:0] mem [DEPTH];

  // NOTE: the array has no reset on purpose -- contents must survive RST_N,
  // and a reset on a memory would turn it into a huge bank of flops.
  always_ff @(posedge CLK) begin
    if (writeEn) begin
      mem[writeAddr] <= writeData;
    end
  end

  assign readData = mem[readAddr];
  assign dumpData = mem[dumpAddr];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, data RAM access, branch resolution and
// a one-shot RAM dump engine that streams every word out after dump_req.
module mem_stage
  import cpu_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          RegWriteE,
  input  logic          MemtoRegE,
  input  logic          MemWriteE,
  input  logic          BranchE,
  input  logic          JumpE,
  input  logic [5:0]    ALUopE,
  input  logic [31:0]   ALUOut_in,
  input  logic [31:0]   WriteData_in,
  input  logic [31:0]   PCPlus4_in,
  input  logic [31:0]   PCBranch_in,
  input  logic [4:0]    wb_addr_in,
  input  logic          dump_req,
  output logic          RegWriteM,
  output logic          MemtoRegM,
  output logic          JumpM,
  output logic [5:0]    ALUopM,
  output logic [31:0]   ALUOutM,
  output logic [31:0]   PCPlus4M,
  output logic [31:0]   PCBranchM,
  output logic [4:0]    wb_addr_M,
  output logic [31:0]   ReadDataM,
  output logic          PCSrcM,
  output logic          dump_valid,
  output logic [AW-1:0] dump_addr,
  output logic [31:0]   dump_data,
  output logic          busy,
  output logic          dump_done
);

  logic          MemWriteM;
  logic          BranchM;
  logic [31:0]   WriteDataM;
  logic [AW-1:0] wordAddr;
  logic          ramWriteEn;
  logic [31:0]   ramDumpData;

  dumpState_t    state, stateNext;
  logic [AW-1:0] counter, counterNext;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of process ordering.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      RegWriteM  <= 1'b0;
      MemtoRegM  <= 1'b0;
      MemWriteM  <= 1'b0;
      BranchM    <= 1'b0;
      JumpM      <= 1'b0;
      ALUopM     <= '0;
      ALUOutM    <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
      PCBranchM  <= '0;
      wb_addr_M  <= '0;
    end else begin
      RegWriteM  <= RegWriteE;
      MemtoRegM  <= MemtoRegE;
      MemWriteM  <= MemWriteE;
      BranchM    <= BranchE;
      JumpM      <= JumpE;
      ALUopM     <= ALUopE;
      ALUOutM    <= ALUOut_in;
      WriteDataM <= WriteData_in;
      PCPlus4M   <= PCPlus4_in;
      PCBranchM  <= PCBranch_in;
      wb_addr_M  <= wb_addr_in;
    end
  end

  // Byte offset and upper bits are dropped, so addresses wrap modulo DEPTH.
  assign wordAddr   = ALUOutM[AW+1:2];
  assign ramWriteEn = MemWriteM && (state == ST_IDLE);
  assign PCSrcM     = branchTaken(BranchM, ALUopM, ALUOutM);

  main_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_main_ram (
    .CLK       (CLK),
    .writeEn   (ramWriteEn),
    .writeAddr (wordAddr),
    .writeData (WriteDataM),
    .readAddr  (wordAddr),
    .readData  (ReadDataM),
    .dumpAddr  (counter),
    .dumpData  (ramDumpData)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state   <= ST_IDLE;
      counter <= '0;
    end else begin
      state   <= stateNext;
      counter <= counterNext;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a value held and infer a latch.
  always_comb begin
    stateNext   = state;
    counterNext = counter;
    dump_valid  = 1'b0;
    dump_done   = 1'b0;
    busy        = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (dump_req) begin
          stateNext   = ST_DUMP;
          counterNext = '0;
        end
      end
      ST_DUMP: begin
        busy       = 1'b1;
        dump_valid = 1'b1;
        if (counter == AW'(DEPTH - 1)) begin
          stateNext = ST_DONE;
        end else begin
          counterNext = counter + 1'b1;
        end
      end
      ST_DONE: begin
        busy      = 1'b1;
        dump_done = 1'b1;
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  assign dump_addr = counter;
  assign dump_data = ramDumpData;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: random pipeline traffic and directed
// store/load, branch, wrap, dump and mid-dump reset scenarios vs a word model.
module tb_mem_stage;

  localparam int DEPTH = 512;
  localparam int AW    = 9;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_JAL = 6'b000011;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          RegWriteE, MemtoRegE, MemWriteE, BranchE, JumpE;
  logic [5:0]    ALUopE;
  logic [31:0]   ALUOut_in, WriteData_in, PCPlus4_in, PCBranch_in;
  logic [4:0]    wb_addr_in;
  logic          dump_req;
  logic          RegWriteM, MemtoRegM, JumpM;
  logic [5:0]    ALUopM;
  logic [31:0]   ALUOutM, PCPlus4M, PCBranchM;
  logic [4:0]    wb_addr_M;
  logic [31:0]   ReadDataM;
  logic          PCSrcM;
  logic          dump_valid;
  logic [AW-1:0] dump_addr;
  logic [31:0]   dump_data;
  logic          busy, dump_done;

  mem_stage #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .RegWriteE    (RegWriteE),
    .MemtoRegE    (MemtoRegE),
    .MemWriteE    (MemWriteE),
    .BranchE      (BranchE),
    .JumpE        (JumpE),
    .ALUopE       (ALUopE),
    .ALUOut_in    (ALUOut_in),
    .WriteData_in (WriteData_in),
    .PCPlus4_in   (PCPlus4_in),
    .PCBranch_in  (PCBranch_in),
    .wb_addr_in   (wb_addr_in),
    .dump_req     (dump_req),
    .RegWriteM    (RegWriteM),
    .MemtoRegM    (MemtoRegM),
    .JumpM        (JumpM),
    .ALUopM       (ALUopM),
    .ALUOutM      (ALUOutM),
    .PCPlus4M     (PCPlus4M),
    .PCBranchM    (PCBranchM),
    .wb_addr_M    (wb_addr_M),
    .ReadDataM    (ReadDataM),
    .PCSrcM       (PCSrcM),
    .dump_valid   (dump_valid),
    .dump_addr    (dump_addr),
    .dump_data    (dump_data),
    .busy         (busy),
    .dump_done    (dump_done)
  );

  always #5 CLK = ~CLK;

  // Reference model: the instruction currently in M, the RAM as a word array,
  // and the dump as a beat index (-1 when no beat is on the bus).
  typedef struct packed {
    logic        regWrite, memToReg, memWrite, branch, jump;
    logic [5:0]  op;
    logic [31:0] alu, wd, pc4, pcb;
    logic [4:0]  wb;
  } mInstr_t;

  mInstr_t     mM = '0;
  logic [31:0] modelRam [DEPTH];
  bit          known [DEPTH];
  bit          mBusy = 1'b0;
  bit          mDone = 1'b0;
  int          mBeat = -1;
  int          nAssert = 0;
  int          nFail = 0;

  function automatic int wordOf(input logic [31:0] byteAddr);
    return int'(byteAddr >> 2) % DEPTH;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idleInputs();
    RegWriteE = 0; MemtoRegE = 0; MemWriteE = 0; BranchE = 0; JumpE = 0;
    ALUopE = '0; ALUOut_in = '0; WriteData_in = '0;
    PCPlus4_in = '0; PCBranch_in = '0; wb_addr_in = '0; dump_req = 0;
  endtask

  task automatic randomInputs();
    RegWriteE = 1'($urandom); MemtoRegE = 1'($urandom); BranchE = 1'($urandom);
    JumpE = 1'($urandom);
    MemWriteE = ($urandom_range(0, 3) == 0);
    case ($urandom_range(0, 5))
      0: ALUopE = OP_LW;
      1: ALUopE = OP_SW;
      2: ALUopE = OP_BEQ;
      3: ALUopE = OP_BNE;
      4: ALUopE = OP_JAL;
      default: ALUopE = 6'($urandom);
    endcase
    ALUOut_in    = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
    WriteData_in = $urandom;
    PCPlus4_in   = $urandom;
    PCBranch_in  = $urandom;
    wb_addr_in   = 5'($urandom);
    dump_req     = 1'b0;
  endtask

  // One rising edge: advance the model exactly as the edge does, then compare.
  task automatic tick();
    int idx;
    @(posedge CLK);
    if (mM.memWrite && !mBusy) begin
      modelRam[wordOf(mM.alu)] = mM.wd;
      known[wordOf(mM.alu)]    = 1'b1;
    end
    if (!RST_N) begin
      mM = '0; mBusy = 1'b0; mDone = 1'b0; mBeat = -1;
    end else begin
      mM = '{RegWriteE, MemtoRegE, MemWriteE, BranchE, JumpE, ALUopE,
             ALUOut_in, WriteData_in, PCPlus4_in, PCBranch_in, wb_addr_in};
      if (!mBusy && dump_req) begin
        mBusy = 1'b1;
        mBeat = 0;
      end else if (mBeat >= 0) begin
        mBeat++;
        if (mBeat == DEPTH) begin
          mBeat = -1;
          mDone = 1'b1;
        end
      end
    end
    #1;
    check("RegWriteM", RegWriteM, mM.regWrite);
    check("MemtoRegM", MemtoRegM, mM.memToReg);
    check("JumpM", JumpM, mM.jump);
    check("ALUopM", ALUopM, mM.op);
    check("ALUOutM", ALUOutM, mM.alu);
    check("PCPlus4M", PCPlus4M, mM.pc4);
    check("PCBranchM", PCBranchM, mM.pcb);
    check("wb_addr_M", wb_addr_M, mM.wb);
    check("PCSrcM", PCSrcM, mM.branch && ((mM.op == OP_BEQ && mM.alu == 0) ||
                                          (mM.op == OP_BNE && mM.alu != 0)));
    idx = wordOf(mM.alu);
    if (known[idx]) check("ReadDataM", ReadDataM, modelRam[idx]);
    check("busy", busy, mBusy);
    check("dump_done", dump_done, mDone);
    check("dump_valid", dump_valid, mBeat >= 0);
    if (mBeat >= 0) begin
      check("dump_addr", dump_addr, mBeat);
      if (known[mBeat]) check("dump_data", dump_data, modelRam[mBeat]);
    end
  endtask

  task automatic preload();
    for (int i = 0; i < DEPTH; i++) begin
      idleInputs();
      MemWriteE = 1'b1; ALUopE = OP_SW;
      ALUOut_in = 32'(i) << 2; WriteData_in = 32'(i);
      tick();
    end
    idleInputs();
    tick();
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0;
    idleInputs();
    tick();
    randomInputs();
    tick();
    check("rst_busy", busy, 0);
    check("rst_dump_valid", dump_valid, 0);
    check("rst_ALUOutM", ALUOutM, 0);
    RST_N = 1'b1;
    idleInputs();

    preload();

    // Store then load the same address.
    MemWriteE = 1; ALUopE = OP_SW; ALUOut_in = 32'h10; WriteData_in = 32'hDEADBEEF;
    tick();
    idleInputs();
    ALUopE = OP_LW; ALUOut_in = 32'h10; MemtoRegE = 1; RegWriteE = 1;
    tick();
    check("lw_after_sw", ReadDataM, 32'hDEADBEEF);

    // Branch resolution.
    idleInputs();
    BranchE = 1; ALUopE = OP_BEQ; ALUOut_in = 0;
    tick();
    check("beq_taken", PCSrcM, 1);
    ALUopE = OP_BNE; ALUOut_in = 0;
    tick();
    check("bne_not_taken", PCSrcM, 0);
    ALUOut_in = 32'h4;
    tick();
    check("bne_taken", PCSrcM, 1);
    BranchE = 0; ALUopE = OP_BEQ; ALUOut_in = 0;
    tick();
    check("no_branch", PCSrcM, 0);

    for (int n = 0; n < 300; n++) begin
      randomInputs();
      tick();
    end

    // Dump 1: RAM[i]=i, stores issued during the dump must not land.
    preload();
    dump_req = 1;
    tick();
    dump_req = 0;
    for (int b = 0; b < DEPTH; b++) begin
      check("dump1_valid", dump_valid, 1);
      check("dump1_addr", dump_addr, b);
      check("dump1_data", dump_data, b);
      idleInputs();
      if (b < 4) begin
        MemWriteE = 1; ALUOut_in = 32'h0; WriteData_in = 32'h00000BAD;
      end
      tick();
    end
    check("dump1_end_valid", dump_valid, 0);
    check("dump1_done", dump_done, 1);
    check("dump1_busy", busy, 1);
    idleInputs();
    dump_req = 1; ALUopE = OP_LW; ALUOut_in = 32'h0;
    tick();
    dump_req = 0;
    tick();
    check("ram0_unchanged", ReadDataM, 32'h0);
    check("done_sticky", dump_done, 1);

    // Dump 2: store to a wrapped, misaligned address completes before the dump.
    RST_N = 0;
    idleInputs();
    tick();
    RST_N = 1;
    MemWriteE = 1; ALUopE = OP_SW; ALUOut_in = 32'h803; WriteData_in = 32'hA5A50803;
    tick();
    idleInputs();
    dump_req = 1;
    tick();
    dump_req = 0;
    check("wrap_addr", dump_addr, 0);
    check("wrap_data", dump_data, 32'hA5A50803);
    for (int b = 1; b <= 100; b++) tick();
    check("beat100_addr", dump_addr, 100);

    // Reset mid-dump, then restart.
    RST_N = 0;
    randomInputs();
    tick();
    check("abort_valid", dump_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", dump_done, 0);
    check("abort_RegWriteM", RegWriteM, 0);
    check("abort_PCSrcM", PCSrcM, 0);
    check("abort_wb_addr_M", wb_addr_M, 0);
    RST_N = 1;
    idleInputs();
    dump_req = 1;
    tick();
    dump_req = 0;
    check("restart_addr", dump_addr, 0);
    check("restart_data", dump_data, 32'hA5A50803);
    for (int c = 0; c < DEPTH + 4 && dump_done !== 1'b1; c++) tick();
    check("dump3_done", dump_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter DEPTH, default 512: data RAM depth in 32-bit words; power of two.
REQ-002 Parameter AW, default 9: word-address width, log2(DEPTH).
REQ-003 Ports (name direction width meaning), in order:
  CLK in 1: single clock, rising edge.
  RST_N in 1: reset, synchronous, active-low.
  RegWriteE, MemtoRegE, MemWriteE, BranchE, JumpE in 1 each: control from EX stage.
  ALUopE in 6: opcode from EX stage.
  ALUOut_in in 32: ALU result; byte address for lw/sw.
  WriteData_in in 32: sw store data.
  PCPlus4_in, PCBranch_in in 32 each: PC+4 and branch target.
  wb_addr_in in 5: write-back register address.
  dump_req in 1: start RAM dump, one-cycle pulse.
  RegWriteM, MemtoRegM, JumpM out 1 each: registered pass-through to WB.
  ALUopM out 6, ALUOutM out 32, PCPlus4M out 32, PCBranchM out 32, wb_addr_M out 5: registered pass-through.
  ReadDataM out 32: RAM word at ALUOutM.
  PCSrcM out 1: branch taken.
  dump_valid out 1, dump_addr out AW, dump_data out 32: dump stream.
  busy out 1, dump_done out 1: dump status.

Function
REQ-004 On every rising CLK with RST_N=1, the EX/MEM register shall capture all *E / *_in inputs; outputs shall follow one cycle later.
REQ-005 Word address shall be ALUOutM[AW+1:2]; bits [1:0] and above AW+1 ignored (wrap modulo DEPTH).
REQ-006 ReadDataM shall be a combinational read of RAM at the word address, valid in the same cycle as ALUOutM.
REQ-007 When MemWriteM=1 and the FSM is IDLE, the RAM shall write WriteDataM at the next rising edge; a same-cycle read returns old data.
REQ-008 PCSrcM shall be BranchM AND ((ALUopM=000100 AND ALUOutM=0) OR (ALUopM=000101 AND ALUOutM!=0)); otherwise 0.
REQ-009 Dump FSM states: IDLE, DUMP, DONE.
REQ-010 IDLE->DUMP on dump_req=1; counter cleared to 0; dump_req ignored outside IDLE.
REQ-011 In DUMP, each cycle: dump_valid=1, dump_addr=counter, dump_data=RAM[counter]; counter increments.
REQ-012 DUMP->DONE after address DEPTH-1 is emitted; exactly DEPTH valid beats, no gaps.
REQ-013 DONE: dump_done=1, dump_valid=0; stays in DONE until reset.
REQ-014 busy shall be 1 in DUMP and DONE.
REQ-015 While busy=1, RAM writes shall be suppressed; pipeline register continues capturing.
REQ-016 MemWriteM=1 in the dump_req cycle shall complete before the dump starts, so dump reflects that store.

Reset
REQ-017 With RST_N=0 at a rising edge: all M-stage control outputs (RegWriteM, MemtoRegM, MemWriteM, BranchM, JumpM) shall go 0; ALUopM, ALUOutM, PCPlus4M, PCBranchM, wb_addr_M shall go 0; PCSrcM shall therefore be 0.
REQ-018 Reset shall force the FSM to IDLE, with counter=0, dump_valid=0, dump_done=0, busy=0; a mid-dump reset aborts the dump.
REQ-019 RAM contents shall not be altered by reset.

Structure
REQ-020 The shared cpu package shall hold opcode constants (OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_JAL) and the dump-state encoding.
REQ-021 The data RAM shall be one sub-module, main_ram (single write port, asynchronous read port, second async read port for dump).

Verification
REQ-022 sw: ALUOut_in=0x10, WriteData_in=0xDEADBEEF, MemWriteE=1; then lw with ALUOut_in=0x10 -> ReadDataM=0xDEADBEEF two cycles later.
REQ-023 beq/bne: BranchE=1, ALUopE=000100, ALUOut_in=0 -> PCSrcM=1; ALUopE=000101, ALUOut_in=0 -> PCSrcM=0; BranchE=0 -> PCSrcM=0.
REQ-024 Wrap/alignment: sw to 0x803 (DEPTH=512) -> dump shows word at dump_addr=0.
REQ-025 Dump: preload RAM[i]=i; pulse dump_req -> 512 consecutive beats with dump_addr=dump_data=0..511, then dump_done=1 and busy=1.
REQ-026 Write during dump: MemWriteE=1 to 0x0 while busy=1 -> RAM[0] unchanged after the dump.
REQ-027 Reset mid-dump at beat 100: next cycle dump_valid=0, busy=0, all M outputs 0; a new dump_req restarts at dump_addr=0.
